// File: rtl/preload_reg_bank.sv
// Per-channel preload/active register bank with held or direct writes and a commit strobe.
// Optional PRELOAD_READBACK_EN adds rd_sel to read the preload register instead of the active one.
module preload_reg_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      srst,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [CHANNELS-1:0]       direct,
    input  logic                      update,
`ifdef PRELOAD_READBACK_EN
    input  logic                      rd_sel,
`endif
    input  logic [AW-1:0]             rd_addr,
    output logic [CHANNELS*WIDTH-1:0] active_q,
    output logic [CHANNELS-1:0]       pending,
    output logic                      update_done,
    output logic [WIDTH-1:0]          rd_data
);

    logic [CHANNELS*WIDTH-1:0] preload_q;
    logic [CHANNELS*WIDTH-1:0] preload_d;
    logic [CHANNELS*WIDTH-1:0] active_d;
    logic [CHANNELS-1:0]       pending_q;
    logic [CHANNELS-1:0]       pending_d;
    logic                      update_done_q;
    logic                      update_done_d;

    assign pending     = pending_q;
    assign update_done = update_done_q;

    // Next-state: write and commit per channel. A held write landing on a channel that is
    // being committed in the same edge is written straight through to active.
    always_comb begin
        preload_d     = preload_q;
        active_d      = active_q;
        pending_d     = pending_q;
        update_done_d = 1'b0;
        if (srst) begin
            preload_d     = '0;
            active_d      = '0;
            pending_d     = '0;
            update_done_d = 1'b0;
        end else begin
            update_done_d = update & (|pending_q);
            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_en && (wr_addr == AW'(n))) begin
                    preload_d[n*WIDTH +: WIDTH] = wr_data;
                    if (direct[n] || (update && pending_q[n])) begin
                        active_d[n*WIDTH +: WIDTH] = wr_data;
                        pending_d[n]               = 1'b0;
                    end else begin
                        pending_d[n] = 1'b1;
                    end
                end else if (update && pending_q[n]) begin
                    active_d[n*WIDTH +: WIDTH] = preload_q[n*WIDTH +: WIDTH];
                    pending_d[n]               = 1'b0;
                end else begin
                    pending_d[n] = pending_q[n];
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            preload_q     <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            update_done_q <= 1'b0;
        end else begin
            preload_q     <= preload_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            update_done_q <= update_done_d;
        end
    end

    // Readback mux; addresses beyond the last channel read as zero.
    always_comb begin
        rd_data = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (rd_addr == AW'(n)) begin
`ifdef PRELOAD_READBACK_EN
                if (rd_sel) begin
                    rd_data = preload_q[n*WIDTH +: WIDTH];
                end else begin
                    rd_data = active_q[n*WIDTH +: WIDTH];
                end
`else
                rd_data = active_q[n*WIDTH +: WIDTH];
`endif
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: doc/preload_reg_bank.md
PRELOAD_REG_BANK -- requirements
Module: preload_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each channel register.
REQ-002 SHALL have parameter CHANNELS, default 4, number of channels, legal range 1..16; AW = max(1, clog2(CHANNELS)).
REQ-003 SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port srst  input  1  synchronous clear of all state, active-high.
REQ-006 SHALL have port wr_en  input  1  write strobe for preload register at wr_addr.
REQ-007 SHALL have port wr_addr  input  AW  channel index of write.
REQ-008 SHALL have port wr_data  input  WIDTH  write data.
REQ-009 SHALL have port direct  input  CHANNELS  per-channel mode: 1 = write goes straight to active, 0 = write is held until update.
REQ-010 SHALL have port update  input  1  commit strobe: copies pending preloads to active registers.
REQ-011 SHALL have port active_q  output  CHANNELS*WIDTH  active registers, channel n at bits [n*WIDTH +: WIDTH].
REQ-012 SHALL have port pending  output  CHANNELS  per-channel flag: preload differs from active, awaiting update.
REQ-013 SHALL have port update_done  output  1  one-cycle pulse: previous cycle's update committed at least one channel.
REQ-014 SHALL have port rd_addr  input  AW  channel index for readback.
REQ-015 SHALL have port rd_data  output  WIDTH  readback data, combinational from registered state.

Function
REQ-016 Write: wr_en=1, wr_addr<CHANNELS -> preload[wr_addr] <= wr_data on that edge; wr_addr>=CHANNELS -> write ignored, no state change.
REQ-017 Held mode (direct[n]=0): write sets pending[n]=1 on the same edge; active unchanged.
REQ-018 Direct mode (direct[n]=1): write sets active[n] and preload[n] to wr_data on the same edge (latency 1 cycle); pending[n] cleared.
REQ-019 Update: edge with update=1 -> for every n with pending[n]=1, active[n] <= preload[n], pending[n] <= 0; other channels unchanged.
REQ-020 update_done SHALL be 1 for exactly the cycle after an update edge that committed >=1 channel; 0 otherwise, including update with no pending channels.
REQ-021 Simultaneous write and update, same held channel: active[n] <= wr_data (write-through), pending[n] <= 0; counts as a commit for update_done.
REQ-022 Simultaneous write and update, different channels: write handled per REQ-017/018, update per REQ-019, independently.
REQ-023 Repeated writes before update: last write wins; pending stays 1.
REQ-024 direct[n] changing 0->1 while pending[n]=1: pending data kept until next update or next write; no implicit commit.
REQ-025 Priority per edge: srst > write/update; srst=1 clears preload, active, pending, update_done to 0 and ignores wr_en/update.
REQ-026 rd_data = active[rd_addr]; rd_addr>=CHANNELS -> rd_data = 0 (preload readback per REQ-030).

Reset
REQ-027 arst=1 SHALL immediately force preload, active_q, pending, update_done to 0, independent of clk.
REQ-028 arst asserted mid-operation (pending writes outstanding) SHALL discard all pending data; first update after release commits nothing and update_done stays 0.
REQ-029 After arst release, first rising edge SHALL behave as a normal cycle (write/update accepted).

Configuration
REQ-030 Macro PRELOAD_READBACK_EN: when defined, input rd_sel (1 bit) SHALL exist and rd_data = preload[rd_addr] when rd_sel=1, active[rd_addr] when rd_sel=0; when undefined, rd_sel SHALL not exist and rd_data always returns active per REQ-026.

Verification
REQ-031 arst pulse, then idle -> active_q=0, pending=0, update_done=0, rd_data=0.
REQ-032 direct=0, write ch1=0x1234, rd_addr=1 -> active unchanged 0, pending=4'b0010; update pulse -> active ch1=0x1234, pending=0, update_done=1 next cycle only.
REQ-033 direct=4'b0100, write ch2=0xBEEF -> active ch2=0xBEEF after one edge, pending=0; update alone -> update_done stays 0.
REQ-034 Pending ch0=0x0001; same edge: write ch0=0x00AA with update=1 -> active ch0=0x00AA, pending=0, update_done=1.
REQ-035 Pending ch3=0x5555, srst=1 with update=1 same edge -> all 0, update_done=0; write with wr_addr out of range (CHANNELS=3, addr=3) -> no change.
REQ-036 PRELOAD_READBACK_EN defined: pending ch1=0x0F0F, rd_sel=1 -> rd_data=0x0F0F; rd_sel=0 -> rd_data=0 until update.
